morse_numero_decoder: RTL and testbench
=======================================

// Module: morse_numero_decoder
// PURPOSE
//   Receive-side decoder for Morse digits, the inverse of the digit encoder.
//   Times a single-key input (chave) and classifies each press as dot or dash.
//   Collects the 5-symbol pattern, then outputs the decoded digit 0-9 with a valid pulse.
//   Sits between the key/button input and the display logic.
// PARAMETERS
//   TICKS_PER_UNIT  5000000  clock cycles per Morse time unit (tests use 4)
//   DOT_MAX_UNITS   2        press of fewer units = dot, otherwise dash
//   LONG_UNITS      7        press of >= this many units = invalid symbol
//   GAP_UNITS       3        release of this many units ends the character
// PORTS
//   clock     in   1  single clock; all state updates on its rising edge
//   reset_n   in   1  asynchronous, active-low reset
//   chave     in   1  raw key, 1 = pressed; asynchronous to clock
//   numero    out  4  last decoded digit, binary 0-9
//   simbolos  out  5  last decoded pattern; [4] = first symbol; 1 = dash, 0 = dot
//   valido    out  1  one-cycle pulse: numero/simbolos just updated
//   erro      out  1  one-cycle pulse: character rejected
// BEHAVIOUR
//   Reset (async, reset_n=0):
//     - Outputs: numero=0, simbolos=5'b11111, valido=0, erro=0.
//     - Internal: sync flops=0, FSM=IDLE, counters=0, shift reg=0, nsym=0, fault=0.
//   Input sync: chave passes through 2 flops to give key_s.
//     - All edges are detected on key_s against its 1-cycle-delayed copy.
//   Timing: prescaler counts 0..TICKS_PER_UNIT-1.
//     - Its wrap increments a unit counter that saturates at LONG_UNITS.
//     - Both counters clear on every key_s edge.
//   FSM states:
//     - IDLE: wait. Rise of key_s -> PRESS.
//     - PRESS: on fall of key_s, units = whole units elapsed while key_s was high.
//         units < DOT_MAX_UNITS -> shift in 0 (dot).
//         DOT_MAX_UNITS <= units < LONG_UNITS -> shift in 1 (dash).
//         units >= LONG_UNITS -> set fault.
//         Shift: sreg <= {sreg[3:0], bit}; nsym++ (3 bits, saturating at 6).
//         Then go to GAP.
//     - GAP: rise of key_s before GAP_UNITS -> PRESS (same character).
//         When the unit counter reaches GAP_UNITS -> close the character -> IDLE,
//         and clear sreg, nsym and fault.
//   Character close, same clock edge:
//     - If fault=0, nsym==5 and sreg is in the table below: load numero and
//       simbolos=sreg; valido=1 for exactly 1 cycle.
//     - Otherwise: erro=1 for exactly 1 cycle; numero/simbolos unchanged.
//   Decode table (sreg -> numero); any other pattern is an error:
//     11111->0  01111->1  00111->2  00011->3  00001->4
//     00000->5  10000->6  11000->7  11100->8  11110->9
//   Pulse rules: valido and erro are mutually exclusive and never high on
//     consecutive cycles.
//   Latency: valido/erro fire 2 + GAP_UNITS*TICKS_PER_UNIT (+1) cycles after
//     chave falls.
//   Boundary conditions:
//     - 6th or later symbol: nsym saturates, so the character closes with erro.
//     - Key held indefinitely: unit counter saturates; no output until release.
//     - Gap of exactly GAP_UNITS-1 units: same character continues.
//     - Glitch shorter than the sync window may be missed; no debounce in this block.
//     - Key already high when reset releases: seen as a rise -> PRESS,
//       timed from that point.
//     - reset_n low mid-character: everything aborts immediately; no pulse.
//     - numero/simbolos hold their value indefinitely between characters.
// TESTING  (TICKS_PER_UNIT=4; dot = 1 unit high, dash = 3 units high,
//           intra gap = 1 unit, end gap = 4 units)
//   1. Send . . . - - -> one valido pulse; numero=3, simbolos=00011; erro stays 0.
//   2. Send - - - - - then 5 . -> numero=0 then numero=5; exactly 2 valido pulses.
//   3. Send . - . - . (01010) -> erro pulse; numero/simbolos keep prior value.
//   4. Send 4 symbols then end gap -> erro.
//      Send 6 dots then end gap -> erro.
//      Neither changes outputs.
//   5. Hold key 8 units inside a character, then finish 5 symbols -> erro, not valido.
//   6. Drop reset_n for 1 cycle after 3 symbols, then send 1 (.----) -> numero=1.
//      No pulse comes from the aborted character.

Source files
------------

// File: rtl/morse_numero_decoder.sv
// ---------------------------------------------------------------------------
// morse_numero_decoder
//   Receive-side Morse digit decoder. Times each press of a single key,
//   classifies it as dot or dash, collects the 5-symbol pattern and, once the
//   key has been released for GAP_UNITS units, emits the decoded digit 0-9
//   with a one-cycle valid pulse (or a one-cycle error pulse).
//
// Ports
//   clock       in   1  single clock, rising edge
//   reset_n     in   1  asynchronous active-low reset
//   chave       in   1  raw key, 1 = pressed, asynchronous to clock
//   numero      out  4  last decoded digit (binary 0-9)
//   simbolos    out  5  last decoded pattern, [4] = first symbol, 1 = dash
//   valido      out  1  one-cycle pulse: numero/simbolos just updated
//   erro        out  1  one-cycle pulse: character rejected
//   dbg_state_o out  2  current FSM state (0 = IDLE, 1 = PRESS, 2 = GAP)
// ---------------------------------------------------------------------------
module morse_numero_decoder #(
    parameter int TICKS_PER_UNIT = 5000000,
    parameter int DOT_MAX_UNITS  = 2,
    parameter int LONG_UNITS     = 7,
    parameter int GAP_UNITS      = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       chave,
    output logic [3:0] numero,
    output logic [4:0] simbolos,
    output logic       valido,
    output logic       erro,
    output logic [1:0] dbg_state_o
);

    localparam int PW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam int UW = $clog2(LONG_UNITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t        state_q;
    logic          sync1_q;
    logic          key_s_q;
    logic          key_dly_q;
    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic [UW-1:0] units_q;
    logic [UW-1:0] units_d;
    logic [4:0]    sreg_q;
    logic [2:0]    nsym_q;
    logic          fault_q;

    logic          key_rise;
    logic          key_fall;
    logic          wrap;
    logic [UW-1:0] press_units;
    logic          sym_bit;
    logic          sym_long;
    logic          dec_ok;
    logic [3:0]    dec_num;

    assign dbg_state_o = state_q;

    always_comb begin
        key_rise = key_s_q & ~key_dly_q;
        key_fall = ~key_s_q & key_dly_q;
        wrap     = (pre_q == PW'(TICKS_PER_UNIT - 1));

        // Prescaler and unit counter restart on every key edge, so each
        // press and each gap is timed from its own start.
        pre_d   = pre_q;
        units_d = units_q;
        if (key_rise || key_fall) begin
            pre_d   = '0;
            units_d = '0;
        end else begin
            pre_d = wrap ? '0 : pre_q + PW'(1);
            if (wrap && (units_q < UW'(LONG_UNITS))) begin
                units_d = units_q + UW'(1);
            end
        end

        // On the fall cycle the unit that completes in this very cycle is
        // counted too, so a press of N*TICKS_PER_UNIT cycles reads as N units.
        press_units = units_q;
        if (wrap && (units_q < UW'(LONG_UNITS))) begin
            press_units = units_q + UW'(1);
        end
        sym_long = (press_units >= UW'(LONG_UNITS));
        sym_bit  = (press_units >= UW'(DOT_MAX_UNITS));

        dec_ok  = 1'b1;
        dec_num = 4'd0;
        case (sreg_q)
            5'b11111: dec_num = 4'd0;
            5'b01111: dec_num = 4'd1;
            5'b00111: dec_num = 4'd2;
            5'b00011: dec_num = 4'd3;
            5'b00001: dec_num = 4'd4;
            5'b00000: dec_num = 4'd5;
            5'b10000: dec_num = 4'd6;
            5'b11000: dec_num = 4'd7;
            5'b11100: dec_num = 4'd8;
            5'b11110: dec_num = 4'd9;
            default:  dec_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= 1'b0;
            key_s_q   <= 1'b0;
            key_dly_q <= 1'b0;
            pre_q     <= '0;
            units_q   <= '0;
            state_q   <= IDLE;
            sreg_q    <= 5'b00000;
            nsym_q    <= 3'd0;
            fault_q   <= 1'b0;
            numero    <= 4'd0;
            simbolos  <= 5'b11111;
            valido    <= 1'b0;
            erro      <= 1'b0;
        end else begin
            sync1_q   <= chave;
            key_s_q   <= sync1_q;
            key_dly_q <= key_s_q;
            pre_q     <= pre_d;
            units_q   <= units_d;
            valido    <= 1'b0;
            erro      <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (key_rise) begin
                        state_q <= PRESS;
                    end
                end
                PRESS: begin
                    if (key_fall) begin
                        if (sym_long) begin
                            fault_q <= 1'b1;
                        end
                        sreg_q <= {sreg_q[3:0], sym_bit};
                        if (nsym_q < 3'd6) begin
                            nsym_q <= nsym_q + 3'd1;
                        end
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    if (key_rise) begin
                        state_q <= PRESS;
                    end else if (units_q >= UW'(GAP_UNITS)) begin
                        if (!fault_q && (nsym_q == 3'd5) && dec_ok) begin
                            numero   <= dec_num;
                            simbolos <= sreg_q;
                            valido   <= 1'b1;
                        end else begin
                            erro <= 1'b1;
                        end
                        sreg_q  <= 5'b00000;
                        nsym_q  <= 3'd0;
                        fault_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_numero_decoder.sv
// ---------------------------------------------------------------------------
// tb_morse_numero_decoder
//   Directed bench for the Morse digit decoder with TICKS_PER_UNIT = 4.
//   Each character is described as a list of press lengths in units; the
//   model turns that list into the expected outcome (digit or error) and
//   queues it. One compare process checks the outputs on every cycle.
// ---------------------------------------------------------------------------
module tb_morse_numero_decoder;

    localparam int T = 4;

    logic       clock;
    logic       reset_n;
    logic       chave;
    logic [3:0] numero;
    logic [4:0] simbolos;
    logic       valido;
    logic       erro;
    logic [1:0] dbg_state;

    int checks   = 0;
    int failures = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;

    // Expected event: {is_valid, numero, simbolos}
    logic [9:0] exp_q[$];
    logic [3:0] cur_num = 4'd0;
    logic [4:0] cur_sym = 5'b11111;
    logic       prev_pulse = 1'b0;
    int         syms[$];
    logic [4:0] digit_pat[10];

    morse_numero_decoder #(
        .TICKS_PER_UNIT(T),
        .DOT_MAX_UNITS (2),
        .LONG_UNITS    (7),
        .GAP_UNITS     (3)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .chave      (chave),
        .numero     (numero),
        .simbolos   (simbolos),
        .valido     (valido),
        .erro       (erro),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got no summary, required finish");
        $fatal(1, "timeout");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic key(input logic v, input int units);
        chave = v;
        tick(units * T);
    endtask

    // Model: decide a character's outcome from its press lengths.
    function automatic logic [9:0] expect_char(input int s[$]);
        logic       fault;
        logic [4:0] pat;
        logic [9:0] r;
        fault = 1'b0;
        pat   = 5'b00000;
        for (int i = 0; i < s.size(); i++) begin
            if (s[i] >= 7) fault = 1'b1;
            pat = {pat[3:0], (s[i] >= 2) ? 1'b1 : 1'b0};
        end
        r = 10'd0;
        if (!fault && s.size() == 5) begin
            for (int d = 0; d < 10; d++) begin
                if (digit_pat[d] == pat) r = {1'b1, 4'(d), pat};
            end
        end
        return r;
    endfunction

    // Drive one character (1-unit intra gaps, 4-unit end gap) and queue its outcome.
    task automatic send_char();
        exp_q.push_back(expect_char(syms));
        for (int i = 0; i < syms.size(); i++) begin
            key(1'b1, syms[i]);
            if (i < syms.size() - 1) key(1'b0, 1);
        end
        key(1'b0, 4);
        tick(8);
    endtask

    // ---------------- compare process ----------------
    always @(negedge clock) begin
        logic [9:0] e;
        if (!reset_n) begin
            cur_num = 4'd0;
            cur_sym = 5'b11111;
        end
        checks++;
        if (valido && erro) begin
            failures++;
            $display("FAIL pulse_excl: valido=%0b erro=%0b required not both", valido, erro);
        end
        if (valido || erro) begin
            if (valido) valid_cnt++;
            if (erro) err_cnt++;
            checks++;
            if (prev_pulse) begin
                failures++;
                $display("FAIL pulse_gap: pulse on consecutive cycles, required separated");
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse: valido=%0b erro=%0b required none", valido, erro);
            end else begin
                e = exp_q.pop_front();
                if (valido != e[9]) begin
                    failures++;
                    $display("FAIL pulse_kind: valido=%0b erro=%0b required valido=%0b", valido, erro, e[9]);
                end
                if (e[9]) begin
                    cur_num = e[8:5];
                    cur_sym = e[4:0];
                end
            end
        end
        checks++;
        if (numero !== cur_num || simbolos !== cur_sym) begin
            failures++;
            $display("FAIL outputs: numero=%0d simbolos=%b required numero=%0d simbolos=%b",
                     numero, simbolos, cur_num, cur_sym);
        end
        prev_pulse = valido | erro;
    end

    // ---------------- stimulus ----------------
    initial begin
        digit_pat = '{5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001,
                      5'b00000, 5'b10000, 5'b11000, 5'b11100, 5'b11110};
        reset_n = 1'b0;
        chave   = 1'b0;
        tick(3);
        check("reset_numero", numero, 0);
        check("reset_simbolos", simbolos, 5'b11111);
        check("reset_valido", valido, 0);
        check("reset_erro", erro, 0);
        reset_n = 1'b1;
        tick(4);

        // 1: ...-- -> 3
        syms = '{1, 1, 1, 3, 3};
        send_char();
        check("t1_numero", numero, 3);
        check("t1_simbolos", simbolos, 5'b00011);
        check("t1_valid_cnt", valid_cnt, 1);
        check("t1_err_cnt", err_cnt, 0);

        // 2: ----- -> 0, then ..... -> 5
        syms = '{3, 3, 3, 3, 3};
        send_char();
        check("t2_numero0", numero, 0);
        syms = '{1, 1, 1, 1, 1};
        send_char();
        check("t2_numero5", numero, 5);
        check("t2_simbolos", simbolos, 5'b00000);
        check("t2_valid_cnt", valid_cnt, 3);

        // 3: .-.-. is not a digit
        syms = '{1, 3, 1, 3, 1};
        send_char();
        check("t3_err_cnt", err_cnt, 1);
        check("t3_numero", numero, 5);

        // 4: too few / too many symbols
        syms = '{3, 3, 1, 1};
        send_char();
        syms = '{1, 1, 1, 1, 1, 1};
        send_char();
        check("t4_err_cnt", err_cnt, 3);
        check("t4_simbolos", simbolos, 5'b00000);

        // 5: an 8-unit hold spoils the character
        syms = '{1, 8, 1, 1, 1};
        send_char();
        check("t5_err_cnt", err_cnt, 4);
        check("t5_valid_cnt", valid_cnt, 3);

        // 6: reset mid-character aborts it silently
        key(1'b1, 1); key(1'b0, 1);
        key(1'b1, 3); key(1'b0, 1);
        key(1'b1, 1); key(1'b0, 1);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        check("t6_reset_numero", numero, 0);
        tick(24);
        syms = '{1, 3, 3, 3, 3};
        send_char();
        check("t6_numero", numero, 1);
        check("t6_simbolos", simbolos, 5'b01111);
        check("t6_valid_cnt", valid_cnt, 4);
        check("t6_err_cnt", err_cnt, 4);
        check("pending_events", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
